div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle RV32M divide/remainder execution unit, the consumer end of the decode-to-execute interface for R-type `funct7 = 0000001`, `funct3[2] = 1` (DIV, DIVU, REM, REMU). Decode provides the operands, `funct3` and the destination register. The unit runs a radix-2 restoring division, one quotient bit per cycle, and returns a single-cycle writeback pulse. The pipeline stalls on `start_i | busy_o`.

## Interface
- No parameters. XLEN fixed at 32.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `start_i` input 1: request a divide. Accepted only in IDLE.
- `op1_i` input 32: dividend (rs1 data).
- `op2_i` input 32: divisor (rs2 data).
- `funct3_i` input 3: 100 DIV, 101 DIVU, 110 REM, 111 REMU. Other values with `start_i` are ignored.
- `reg_wr_addr_i` input 5: destination rd.
- `flush_i` input 1: pipeline flush (taken jump/branch). Aborts any operation in flight.
- `busy_o` output 1: high in CALC and DONE.
- `done_o` output 1: one-cycle completion pulse.
- `result_o` output 32: quotient or remainder. Valid when `done_o` is high; holds its value afterwards.
- `reg_wr_en_o` output 1: equals `done_o`.
- `reg_wr_addr_o` output 5: latched rd. Valid with `done_o`.

## Operation
- FSM states: IDLE, CALC, DONE.
- Accept condition: IDLE & `start_i` & !`flush_i` & `funct3_i[2]`. On accept, latch:
  - op kind: div/rem = `funct3[1]`; signed = !`funct3[0]`.
  - rd.
  - sign flags: s1 = signed & `op1[31]`; s2 = signed & `op2[31]`.
  - magnitudes: |op1| and |op2|, computed in 32-bit unsigned. |0x80000000| = 0x80000000.
- Divisor zero (fast path): go directly to DONE. Quotient result = 0xFFFFFFFF; remainder result = `op1_i` unmodified.
- Divisor nonzero: load quo = |op1|, rem = 0, 5-bit counter = 31, then go to CALC.
- Each CALC cycle:
  - shift {rem, quo} left by 1;
  - compute trial = rem − |op2| in 33-bit;
  - if trial ≥ 0: rem = trial[31:0] and quo[0] = 1.
  - The counter decrements; leave CALC to DONE on the cycle the counter is 0.
- Exit fixup, registered into `result_o` on the transition into DONE:
  - quotient negated if s1 ^ s2;
  - remainder negated if s1.
  - Signed overflow (0x80000000 / −1) falls out naturally: quotient 0x80000000, remainder 0.
- DONE: `done_o` = `reg_wr_en_o` = 1 for exactly one cycle, then return to IDLE.
- `start_i` in CALC or DONE is ignored. Decode holds it until it is accepted.
- Flush:
  - `flush_i` in CALC returns the FSM to IDLE on the next edge; no `done_o`.
  - `flush_i` in DONE does not suppress that cycle's writeback: the instruction is already older than the flushing one.
  - `flush_i` together with `start_i` in IDLE: the start is not accepted.
- Reset (any state, including mid-operation), on the edge with `rst_n` = 0:
  - state = IDLE;
  - `busy_o`, `done_o`, `reg_wr_en_o` = 0;
  - `result_o` = 0, `reg_wr_addr_o` = 0;
  - counter and datapath registers = 0.

## Timing
- All outputs are registered.
- Normal operation, start accepted at edge N:
  - CALC occupies cycles N+1 … N+32;
  - DONE (`done_o` = 1) in cycle N+33;
  - IDLE in cycle N+34. A new start is accepted at the N+34 edge at the earliest.
- Divisor-zero fast path: DONE in cycle N+1; IDLE in N+2.
- `busy_o` rises in cycle N+1 and falls in the cycle after DONE.
- Back-to-back throughput: one divide per 34 cycles (normal) or 2 cycles (divide by zero).

## Structure
- Shared package `riscv_pkg` holds:
  - funct3 constants `F3_DIV`, `F3_DIVU`, `F3_REM`, `F3_REMU`;
  - `OPCODE_OP` (0110011) and `FUNCT7_MULDIV` (0000001);
  - the FSM state enum (2-bit).
- Single module; no sub-module. The step logic is one 33-bit subtract and a mux, kept inline.

## Test plan
- DIVU 100 / 7, then REMU 100 / 7: `result_o` = 14 (then 2) with `done_o` at N+33, `reg_wr_addr_o` = latched rd, `busy_o` high during N+1 … N+33.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; REM 7 / −2 → 1; DIV 7 / −2 → 0xFFFFFFFD.
- Divide by zero: DIV 5 / 0 → 0xFFFFFFFF at N+1; REMU 5 / 0 → 5 at N+1; no CALC cycles.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0; both at N+33.
- `flush_i` pulsed at cycle N+10: no `done_o` ever; IDLE at N+11; a new DIVU 9 / 3 started at N+11 returns 3 at N+44.
- `rst_n` low at cycle N+20 of an operation: on the next edge every output is 0 and the state is IDLE; no `done_o`. `start_i` held high during DONE is not re-accepted until IDLE.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and the divider FSM state type.
package riscv_pkg;

  // Major opcode and funct7 that select the M-extension R-type group
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // funct3 values of the divide/remainder half of the M extension
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  // Divider sequencing states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// RV32M divide/remainder execution unit: radix-2 restoring division,
// one quotient bit per cycle, single-cycle writeback pulse on completion.
module div_unit
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  reg_wr_addr_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        reg_wr_en_o,
  output logic [4:0]  reg_wr_addr_o
);

  div_state_e  state_q;
  div_state_e  state_d;

  logic        accept;
  logic        div_zero;
  logic        op_signed;
  logic        op_is_rem;
  logic        op_s1;
  logic        op_s2;
  logic [31:0] op1_mag;
  logic [31:0] op2_mag;
  logic [31:0] zero_result;

  logic        is_rem_q;
  logic        s1_q;
  logic        s2_q;
  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dvs_q;
  logic [4:0]  cnt_q;

  logic [32:0] shifted_rem;
  logic [32:0] trial;
  logic        trial_ok;
  logic [31:0] quo_step;
  logic [31:0] rem_step;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] final_result;

  assign accept    = (state_q == S_IDLE) & start_i & ~flush_i & funct3_i[2];
  assign op_signed = (funct3_i == F3_DIV) | (funct3_i == F3_REM);
  assign op_is_rem = (funct3_i == F3_REM) | (funct3_i == F3_REMU);
  assign op_s1     = op_signed & op1_i[31];
  assign op_s2     = op_signed & op2_i[31];
  assign op1_mag   = op_s1 ? (32'd0 - op1_i) : op1_i;
  assign op2_mag   = op_s2 ? (32'd0 - op2_i) : op2_i;
  assign div_zero  = (op2_i == 32'd0);

  // Divide by zero: quotient is all ones, remainder is the raw dividend
  assign zero_result = op_is_rem ? op1_i : 32'hFFFF_FFFF;

  // One restoring step. The shifted partial remainder is 33 bits wide; if its
  // top bit is set it certainly exceeds the 32-bit divisor, otherwise the
  // borrow out of the 33-bit subtract decides.
  always_comb begin
    shifted_rem = {rem_q, quo_q[31]};
    trial       = shifted_rem - {1'b0, dvs_q};
    trial_ok    = rem_q[31] | ~trial[32];
    quo_step    = {quo_q[30:0], trial_ok};
    rem_step    = trial_ok ? trial[31:0] : shifted_rem[31:0];
  end

  // Sign fixup applied to the last step's result on the way into DONE
  always_comb begin
    quo_fix      = (s1_q ^ s2_q) ? (32'd0 - quo_step) : quo_step;
    rem_fix      = s1_q ? (32'd0 - rem_step) : rem_step;
    final_result = is_rem_q ? rem_fix : quo_fix;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a flush only matters while the division is iterating
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = div_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 5'd0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Operand latching, iteration datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_rem_q      <= 1'b0;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      quo_q         <= 32'd0;
      rem_q         <= 32'd0;
      dvs_q         <= 32'd0;
      cnt_q         <= 5'd0;
      result_o      <= 32'd0;
      reg_wr_addr_o <= 5'd0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      busy_o <= (state_d != S_IDLE);
      done_o <= (state_d == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            is_rem_q      <= op_is_rem;
            s1_q          <= op_s1;
            s2_q          <= op_s2;
            quo_q         <= op1_mag;
            rem_q         <= 32'd0;
            dvs_q         <= op2_mag;
            cnt_q         <= 5'd31;
            reg_wr_addr_o <= reg_wr_addr_i;
            if (div_zero) begin
              result_o <= zero_result;
            end
          end
        end
        S_CALC: begin
          if (!flush_i) begin
            quo_q <= quo_step;
            rem_q <= rem_step;
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd0) begin
              result_o <= final_result;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign reg_wr_en_o = done_o;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized
// operations against a plain-arithmetic reference model.
module tb_div_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic [2:0]  funct3_i;
  logic [4:0]  reg_wr_addr_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        reg_wr_en_o;
  logic [4:0]  reg_wr_addr_o;

  int checks = 0;
  int errors = 0;

  div_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .op1_i         (op1_i),
    .op2_i         (op2_i),
    .funct3_i      (funct3_i),
    .reg_wr_addr_i (reg_wr_addr_i),
    .flush_i       (flush_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .result_o      (result_o),
    .reg_wr_en_o   (reg_wr_en_o),
    .reg_wr_addr_o (reg_wr_addr_o)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // RISC-V division semantics computed with 64-bit integer arithmetic
  function automatic logic [31:0] refResult(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0]) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return f3[1] ? r[31:0] : q[31:0];
  endfunction

  // Step one cycle and sample away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From the cycle after acceptance, wait (bounded) for done_o
  task automatic waitDone(output int cyc, output bit busy_ok);
    cyc = 1;
    busy_ok = 1'b1;
    while (done_o !== 1'b1 && cyc < 40) begin
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      tick();
      cyc++;
    end
  endtask

  // Verify the completion cycle and the idle cycle that follows
  task automatic checkCompletion(input string tag, input int cyc, input bit busy_ok,
                                 input int lat, input logic [31:0] exp, input logic [4:0] rd);
    checkOutput({tag, " latency"}, 32'(cyc), 32'(lat));
    checkOutput({tag, " result"}, result_o, exp);
    checkOutput({tag, " rd"}, {27'd0, reg_wr_addr_o}, {27'd0, rd});
    checkOutput({tag, " wr_en"}, {31'd0, reg_wr_en_o}, 32'd1);
    checkOutput({tag, " busy_calc"}, {31'd0, busy_ok}, 32'd1);
    checkOutput({tag, " busy_done"}, {31'd0, busy_o}, 32'd1);
    tick();
    checkOutput({tag, " idle_busy"}, {31'd0, busy_o}, 32'd0);
    checkOutput({tag, " idle_done"}, {31'd0, done_o}, 32'd0);
    checkOutput({tag, " held"}, result_o, exp);
  endtask

  // Issue one operation and check it end to end
  task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd);
    int cyc;
    bit busy_ok;
    funct3_i      = f3;
    op1_i         = a;
    op2_i         = b;
    reg_wr_addr_i = rd;
    start_i       = 1'b1;
    tick();
    start_i       = 1'b0;
    waitDone(cyc, busy_ok);
    checkCompletion(tag, cyc, busy_ok, (b == 32'd0) ? 1 : 33, refResult(f3, a, b), rd);
  endtask

  logic [31:0] pool [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd7};

  function automatic logic [31:0] pickOperand();
    if ($urandom_range(0, 3) == 0) return pool[$urandom_range(0, 4)];
    if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 300));
    return $urandom;
  endfunction

  initial begin
    int cyc;
    bit busy_ok;
    bit saw_done;

    rst_n = 1'b0;
    start_i = 1'b0;
    op1_i = 32'd0;
    op2_i = 32'd0;
    funct3_i = 3'd0;
    reg_wr_addr_i = 5'd0;
    flush_i = 1'b0;
    repeat (3) tick();
    checkOutput("reset busy", {31'd0, busy_o}, 32'd0);
    checkOutput("reset done", {31'd0, done_o}, 32'd0);
    checkOutput("reset wr_en", {31'd0, reg_wr_en_o}, 32'd0);
    checkOutput("reset result", result_o, 32'd0);
    checkOutput("reset rd", {27'd0, reg_wr_addr_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    applyStimulus("divu 100/7", F3_DIVU, 32'd100, 32'd7, 5'd3);
    applyStimulus("remu 100/7", F3_REMU, 32'd100, 32'd7, 5'd4);
    applyStimulus("div -7/2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5);
    applyStimulus("rem -7/2", F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd6);
    applyStimulus("rem 7/-2", F3_REM, 32'd7, 32'hFFFF_FFFE, 5'd7);
    applyStimulus("div 7/-2", F3_DIV, 32'd7, 32'hFFFF_FFFE, 5'd8);
    applyStimulus("div 5/0", F3_DIV, 32'd5, 32'd0, 5'd9);
    applyStimulus("remu 5/0", F3_REMU, 32'd5, 32'd0, 5'd10);
    applyStimulus("div ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    applyStimulus("rem ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    applyStimulus("divu big", F3_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd13);
    applyStimulus("remu big", F3_REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd14);

    // Invalid funct3 and start-with-flush are both ignored in IDLE
    funct3_i = 3'b011; op1_i = 32'd9; op2_i = 32'd3; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checkOutput("bad funct3 busy", {31'd0, busy_o}, 32'd0);
    funct3_i = F3_DIVU; start_i = 1'b1; flush_i = 1'b1;
    tick();
    start_i = 1'b0; flush_i = 1'b0;
    checkOutput("start+flush busy", {31'd0, busy_o}, 32'd0);

    // Flush at cycle N+10 aborts; a new divide starts at N+11
    funct3_i = F3_DIVU; op1_i = 32'd1000; op2_i = 32'd3; reg_wr_addr_i = 5'd20; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    saw_done = 1'b0;
    repeat (9) begin
      if (done_o) saw_done = 1'b1;
      tick();
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    if (done_o) saw_done = 1'b1;
    checkOutput("flush idle", {31'd0, busy_o}, 32'd0);
    checkOutput("flush no done", {31'd0, saw_done}, 32'd0);
    applyStimulus("divu 9/3 after flush", F3_DIVU, 32'd9, 32'd3, 5'd21);

    // Reset at cycle N+20 of a divide clears every output
    funct3_i = F3_DIV; op1_i = 32'd77; op2_i = 32'd5; reg_wr_addr_i = 5'd22; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (19) tick();
    rst_n = 1'b0;
    tick();
    checkOutput("midreset busy", {31'd0, busy_o}, 32'd0);
    checkOutput("midreset done", {31'd0, done_o}, 32'd0);
    checkOutput("midreset wr_en", {31'd0, reg_wr_en_o}, 32'd0);
    checkOutput("midreset result", result_o, 32'd0);
    checkOutput("midreset rd", {27'd0, reg_wr_addr_o}, 32'd0);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      if (done_o) saw_done = 1'b1;
      tick();
    end
    checkOutput("midreset no done", {31'd0, saw_done}, 32'd0);

    // start_i held through the whole operation is not re-accepted before IDLE
    funct3_i = F3_DIVU; op1_i = 32'd100; op2_i = 32'd7; reg_wr_addr_i = 5'd23; start_i = 1'b1;
    tick();
    waitDone(cyc, busy_ok);
    checkCompletion("held start", cyc, busy_ok, 33, 32'd14, 5'd23);
    tick();
    start_i = 1'b0;
    checkOutput("held start reaccept", {31'd0, busy_o}, 32'd1);
    waitDone(cyc, busy_ok);
    checkCompletion("held start 2nd", cyc, busy_ok, 33, 32'd14, 5'd23);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      f3 = 3'(4 + $urandom_range(0, 3));
      a  = pickOperand();
      b  = pickOperand();
      applyStimulus($sformatf("rand%0d f3=%0d a=%08h b=%08h", i, f3, a, b), f3, a, b,
                    5'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global bound so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
